// File: rtl/pll_lock_reset_sequencer.sv
// rtl/pll_lock_reset_sequencer.sv - PLL reset/lock supervisor releasing staged downstream resets
module pll_lock_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65535,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGES             = 3,
  parameter int STAGE_GAP          = 16,
  parameter int GLITCH_FILTER      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [STAGES-1:0] rst_out,
  output logic              ready,
  output logic [7:0]        lost_count,
  output logic [7:0]        retry_count
);

  localparam int M0 = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M1 = (M0 > LOCK_STABLE_CYCLES) ? M0 : LOCK_STABLE_CYCLES;
  localparam int TMR_MAX = (M1 > STAGE_GAP) ? M1 : STAGE_GAP;
  localparam int TW = $clog2(TMR_MAX + 1);
  localparam int FW = $clog2(GLITCH_FILTER + 1);

  localparam logic [TW-1:0] C_PLLRST_END = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] C_TIMEOUT    = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] C_STABLE     = TW'(LOCK_STABLE_CYCLES);
  localparam logic [TW-1:0] C_GAP_END    = TW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] C_FILTER     = FW'(GLITCH_FILTER);
  localparam logic [STAGES-1:0] C_LAST   = STAGES'(1) << (STAGES - 1);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [TW-1:0]          r_timer;
  logic [FW-1:0]          r_flt;
  logic                   r_pll_rst;
  logic [STAGES-1:0]      r_rst_out;
  logic                   r_ready;
  logic [7:0]             r_lost;
  logic [7:0]             r_retry;
  logic                   w_lock_s;

  assign w_lock_s    = r_sync[SYNC_STAGES-1];
  assign pll_rst     = r_pll_rst;
  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign lost_count  = r_lost;
  assign retry_count = r_retry;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_PLLRST;
      r_sync    <= '0;
      r_timer   <= '0;
      r_flt     <= '0;
      r_pll_rst <= 1'b1;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_lost    <= '0;
      r_retry   <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      case (r_state)
        S_PLLRST: begin
          r_pll_rst <= 1'b1;
          if (r_timer == C_PLLRST_END) begin
            r_state   <= S_WAIT_LOCK;
            r_pll_rst <= 1'b0;
            r_timer   <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_LOCK: begin
          if (w_lock_s) begin
            r_state <= S_STABLE;
            r_timer <= '0;
          end else if (r_timer == C_TIMEOUT) begin
            r_state   <= S_PLLRST;
            r_pll_rst <= 1'b1;
            r_timer   <= '0;
            if (r_retry != 8'hFF) r_retry <= r_retry + 8'd1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_STABLE: begin
          // Any unlocked sample restarts qualification from scratch.
          if (!w_lock_s) begin
            r_state <= S_WAIT_LOCK;
            r_timer <= '0;
          end else if (r_timer == C_STABLE) begin
            r_state <= S_RELEASE;
            r_timer <= '0;
            r_flt   <= '0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RELEASE, S_RUN: begin
          if (r_flt == C_FILTER) begin
            r_state   <= S_WAIT_LOCK;
            r_rst_out <= '1;
            r_ready   <= 1'b0;
            r_timer   <= '0;
            r_flt     <= '0;
            if (r_lost != 8'hFF) r_lost <= r_lost + 8'd1;
          end else begin
            r_flt <= w_lock_s ? '0 : r_flt + 1'b1;
            if (r_state == S_RELEASE) begin
              // Shifting left clears exactly the lowest still-asserted bit.
              if (r_timer == C_GAP_END) begin
                r_timer   <= '0;
                r_rst_out <= r_rst_out << 1;
                if (r_rst_out == C_LAST) begin
                  r_ready <= 1'b1;
                  r_state <= S_RUN;
                end
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          end
        end
        default: begin
          r_state   <= S_PLLRST;
          r_pll_rst <= 1'b1;
          r_rst_out <= '1;
          r_ready   <= 1'b0;
          r_timer   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb/tb_pll_lock_reset_sequencer.sv - scoreboard bench for pll_lock_reset_sequencer
module tb_pll_lock_reset_sequencer;

  localparam int SYNC = 2, PLLR = 4, TMO = 20, STB = 8, STG = 3, GAP = 4, FLT = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pll_locked = 1'b1;
  logic           pll_rst;
  logic [STG-1:0] rst_out;
  logic           ready;
  logic [7:0]     lost_count;
  logic [7:0]     retry_count;

  pll_lock_reset_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PLLR), .LOCK_TIMEOUT(TMO),
    .LOCK_STABLE_CYCLES(STB), .STAGES(STG), .STAGE_GAP(GAP), .GLITCH_FILTER(FLT)
  ) dut (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_out(rst_out), .ready(ready), .lost_count(lost_count), .retry_count(retry_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int       cyc;
    logic [2:0] rst_out;
    logic     pll_rst;
    logic     ready;
    int       lost;
    int       retry;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d: observed %0d expected %0d", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic push(input int c, input logic [2:0] ro, input logic pr, input logic rd,
                      input int lo, input int re);
    exp_t e;
    e.cyc = c; e.rst_out = ro; e.pll_rst = pr; e.ready = rd; e.lost = lo; e.retry = re;
    sb_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_eq("sb_on_time", cyc, e.cyc);
      check_eq("rst_out", {29'd0, rst_out}, {29'd0, e.rst_out});
      check_eq("pll_rst", {31'd0, pll_rst}, {31'd0, e.pll_rst});
      check_eq("ready", {31'd0, ready}, {31'd0, e.ready});
      check_eq("lost_count", {24'd0, lost_count}, e.lost);
      check_eq("retry_count", {24'd0, retry_count}, e.retry);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed cyc %0d expected finish before bound", cyc);
    $fatal(1);
  end

  initial begin
    // Power-up sequence with lock present from the start.
    push(1, 3'b111, 1, 0, 0, 0);
    push(4, 3'b111, 1, 0, 0, 0);
    push(5, 3'b111, 0, 0, 0, 0);
    push(18, 3'b111, 0, 0, 0, 0);
    push(19, 3'b110, 0, 0, 0, 0);
    push(22, 3'b110, 0, 0, 0, 0);
    push(23, 3'b100, 0, 0, 0, 0);
    push(26, 3'b100, 0, 0, 0, 0);
    push(27, 3'b000, 0, 1, 0, 0);
    push(35, 3'b000, 0, 1, 0, 0);
    wait_until(1);
    rst = 1'b0;

    // Lock glitches in RUN: 3 low cycles filtered, 4 low cycles is a loss.
    wait_until(40);
    push(50, 3'b000, 0, 1, 0, 0);
    push(58, 3'b000, 0, 1, 0, 0);
    push(59, 3'b111, 0, 0, 1, 0);
    push(72, 3'b111, 0, 0, 1, 0);
    push(73, 3'b110, 0, 0, 1, 0);
    push(77, 3'b100, 0, 0, 1, 0);
    push(81, 3'b000, 0, 1, 1, 0);
    pll_locked = 1'b0;
    wait_until(43);
    pll_locked = 1'b1;
    wait_until(52);
    pll_locked = 1'b0;
    wait_until(56);
    pll_locked = 1'b1;

    // Reset clears counters; a one-cycle drop during STABLE restarts qualification.
    wait_until(85);
    push(86, 3'b111, 1, 0, 0, 0);
    push(105, 3'b111, 0, 0, 0, 0);
    push(109, 3'b111, 0, 0, 0, 0);
    push(110, 3'b110, 0, 0, 0, 0);
    push(114, 3'b100, 0, 0, 0, 0);
    push(118, 3'b000, 0, 1, 0, 0);
    rst = 1'b1;
    wait_until(86);
    rst = 1'b0;
    wait_until(93);
    pll_locked = 1'b0;
    wait_until(94);
    pll_locked = 1'b1;

    // No lock: PLL reset re-pulses every TMO+PLLR cycles.
    wait_until(120);
    push(124, 3'b111, 1, 0, 0, 0);
    push(125, 3'b111, 0, 0, 0, 0);
    push(144, 3'b111, 0, 0, 0, 0);
    push(145, 3'b111, 1, 0, 0, 1);
    push(148, 3'b111, 1, 0, 0, 1);
    push(149, 3'b111, 0, 0, 0, 1);
    push(168, 3'b111, 0, 0, 0, 1);
    push(169, 3'b111, 1, 0, 0, 2);
    push(193, 3'b111, 1, 0, 0, 3);
    rst = 1'b1;
    pll_locked = 1'b0;
    wait_until(121);
    rst = 1'b0;

    // Lock arrives; rst asserted mid-RELEASE.
    wait_until(200);
    push(215, 3'b111, 0, 0, 0, 3);
    push(216, 3'b110, 0, 0, 0, 3);
    push(220, 3'b100, 0, 0, 0, 3);
    push(221, 3'b100, 0, 0, 0, 3);
    push(222, 3'b111, 1, 0, 0, 0);
    pll_locked = 1'b1;
    wait_until(221);
    rst = 1'b1;
    wait_until(222);
    rst = 1'b0;

    // 300 filtered losses; lost_count must stick at 255.
    for (int i = 0; i < 300; i++) begin
      int x;
      x = 222 + 24 * i;
      wait_until(x);
      if (i < 2 || (i >= 253 && i <= 256) || i == 299) begin
        push(x + 22, 3'b100, 0, 0, (i < 255) ? i : 255, 0);
        push(x + 23, 3'b111, 0, 0, (i + 1 < 255) ? i + 1 : 255, 0);
      end
      pll_locked = 1'b1;
      wait_until(x + 16);
      pll_locked = 1'b0;
    end
    wait_until(7422);
    push(7446, 3'b000, 0, 1, 255, 0);
    pll_locked = 1'b1;
    wait_until(7450);
    check_eq("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
